// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared constants and state encoding for the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int unsigned DEPTH     = 51200;
    localparam int unsigned ADDR_W    = 16;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    // Header byte positions following the SYNC byte
    localparam logic [1:0] HDR_ADDR_LO = 2'd0;
    localparam logic [1:0] HDR_ADDR_HI = 2'd1;
    localparam logic [1:0] HDR_LEN_LO  = 2'd2;
    localparam logic [1:0] HDR_LEN_HI  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_packer
// Description : Packs four bytes, first byte lowest, into a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= 32'h0;
            cnt_q  <= 2'd0;
        end else if (clear_i) begin
            word_q <= 32'h0;
            cnt_q  <= 2'd0;
        end else if (byte_valid_i) begin
            word_q <= {byte_i, word_q[31:8]};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    // Flags the byte that completes a word; the word is in word_o next cycle
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o       = word_q;

endmodule
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_loader
// Description : Framed byte-stream boot loader writing 32-bit program memory.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_loader #(
    parameter int unsigned DEPTH     = prog_loader_pkg::DEPTH,
    parameter int unsigned ADDR_W    = prog_loader_pkg::ADDR_W,
    parameter logic [7:0]  SYNC_BYTE = prog_loader_pkg::SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              cpu_reset_req,
    output logic              load_done,
    output logic              load_error
);
    import prog_loader_pkg::*;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        remain_q, remain_d;
    logic [7:0]         csum_q, csum_d;
    logic [23:0]        hdr_q, hdr_d;
    logic [1:0]         hdr_idx_q, hdr_idx_d;

    logic        w_ready_state;
    logic        w_accept;
    logic        w_sync;
    logic [15:0] w_start;
    logic [15:0] w_len;
    logic [16:0] w_end;
    logic [7:0]  w_csum_next;
    logic        w_word_valid;
    logic [31:0] w_word;

    assign w_ready_state = (state_q == ST_IDLE) || (state_q == ST_HDR) ||
                           (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign in_ready      = ~reset & w_ready_state;
    assign w_accept      = in_valid & in_ready;
    assign w_sync        = w_accept && (state_q == ST_IDLE) && (in_data == SYNC_BYTE);

    // Header fields are only meaningful on the last header byte
    assign w_start     = hdr_q[15:0];
    assign w_len       = {in_data, hdr_q[23:16]};
    assign w_end       = {1'b0, w_start} + {1'b0, w_len};
    assign w_csum_next = csum_q + in_data;

    byte_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (w_sync),
        .byte_valid_i (w_accept && (state_q == ST_DATA)),
        .byte_i       (in_data),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            remain_q  <= 16'h0;
            csum_q    <= 8'h0;
            hdr_q     <= 24'h0;
            hdr_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            csum_q    <= csum_d;
            hdr_q     <= hdr_d;
            hdr_idx_q <= hdr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        csum_d    = csum_q;
        hdr_d     = hdr_q;
        hdr_idx_d = hdr_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (w_sync) begin
                    state_d   = ST_HDR;
                    csum_d    = 8'h0;
                    hdr_idx_d = 2'd0;
                end
            end
            ST_HDR: begin
                if (w_accept) begin
                    hdr_d     = {in_data, hdr_q[23:8]};
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == HDR_LEN_HI) begin
                        if (w_end > 17'(DEPTH)) begin
                            state_d = ST_ERROR;
                        end else begin
                            addr_d   = w_start[ADDR_W-1:0];
                            remain_d = w_len;
                            state_d  = (w_len == 16'h0) ? ST_CSUM : ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    csum_d = w_csum_next;
                    if (w_word_valid) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - 16'd1;
                state_d  = (remain_q == 16'd1) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (w_accept) begin
                    state_d = (w_csum_next == 8'h0) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobe decodes straight from the state register so reset kills it at once
    assign mem_write      = (state_q == ST_WRITE);
    assign mem_chipselect = (state_q == ST_WRITE);
    assign mem_byteenable = 4'hF;
    assign mem_address    = addr_q;
    assign mem_writedata  = w_word;
    assign cpu_reset_req  = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                            (state_q == ST_WRITE) || (state_q == ST_CSUM);
    assign load_done      = (state_q == ST_DONE);
    assign load_error     = (state_q == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_mem_loader
// Description : Scoreboard bench for prog_mem_loader frames, bounds and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        cpu_reset_req;
    logic        load_done;
    logic        load_error;

    int checks   = 0;
    int failures = 0;

    logic [47:0] exp_wr[$];
    bit          exp_res[$];
    logic [7:0]  dbuf[$];
    bit          prev_write = 1'b0;

    prog_mem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .cpu_reset_req  (cpu_reset_req),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard whenever the DUT writes or finishes
    always @(negedge clk) begin
        logic [47:0] e;
        if (!reset) begin
            if (mem_write) begin
                chk("strobe_len", prev_write, 1'b0);
                chk("wr_cs", mem_chipselect, 1'b1);
                chk("wr_be", mem_byteenable, 4'hF);
                chk("wr_ready_low", in_ready, 1'b0);
                chk("wr_cpu_rst", cpu_reset_req, 1'b1);
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", exp_wr.size(), 1);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", mem_address, e[47:32]);
                    chk("wr_data", mem_writedata, e[31:0]);
                end
            end
            if (load_done || load_error) begin
                chk("both_pulses", load_done & load_error, 1'b0);
                chk("end_cpu_rst", cpu_reset_req, 1'b0);
                chk("end_writes_left", exp_wr.size(), 0);
                if (exp_res.size() == 0) begin
                    chk("res_unexpected", exp_res.size(), 1);
                end else begin
                    chk("res_kind", load_error, exp_res.pop_front());
                end
            end
        end
        prev_write = mem_write;
    end

    task automatic send_byte(input logic [7:0] b, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) chk("ready_timeout", waits, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        for (int i = 0; i < 12 && exp_res.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("result_timeout", exp_res.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_dbuf(input int nbytes);
        dbuf.delete();
        for (int i = 0; i < nbytes; i++) dbuf.push_back(8'($urandom_range(0, 255)));
    endtask

    // Frame from dbuf; csum is corrected by adj (0 gives a good frame)
    task automatic send_frame(input logic [15:0] start, input logic [15:0] len,
                              input logic [7:0] adj);
        int         w;
        bit         oob;
        logic [7:0] sum;
        oob = ({1'b0, start} + {1'b0, len}) > 17'd51200;
        sum = 8'h0;
        if (!oob) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_wr.push_back({start + 16'(i), dbuf[4*i+3], dbuf[4*i+2],
                                  dbuf[4*i+1], dbuf[4*i]});
            end
        end
        exp_res.push_back(oob || (adj != 8'h0));
        send_byte(8'hA5, w);
        chk("cpu_rst_after_sync", cpu_reset_req, 1'b1);
        send_byte(start[7:0], w);
        send_byte(start[15:8], w);
        send_byte(len[7:0], w);
        send_byte(len[15:8], w);
        if (!oob) begin
            for (int i = 0; i < 4 * int'(len); i++) begin
                send_byte(dbuf[i], w);
                sum = sum + dbuf[i];
            end
            send_byte(8'h0 - sum + adj, w);
        end
        wait_result();
    endtask

    initial begin
        int w;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h0;
        #12;
        chk("rst_write", mem_write, 1'b0);
        chk("rst_cs", mem_chipselect, 1'b0);
        chk("rst_cpu_rst", cpu_reset_req, 1'b0);
        chk("rst_done", load_done, 1'b0);
        chk("rst_error", load_error, 1'b0);
        chk("rst_addr", mem_address, 16'h0);
        chk("rst_wdata", mem_writedata, 32'h0);
        chk("rst_be", mem_byteenable, 4'hF);
        chk("rst_ready", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Garbage ahead of SYNC is swallowed without stalling
        send_byte(8'h00, w); chk("garbage_ready0", w, 0);
        send_byte(8'hFF, w); chk("garbage_ready1", w, 0);
        send_byte(8'h5A, w); chk("garbage_ready2", w, 0);
        chk("garbage_cpu_rst", cpu_reset_req, 1'b0);

        dbuf.delete();
        dbuf.push_back(8'h11); dbuf.push_back(8'h22);
        dbuf.push_back(8'h33); dbuf.push_back(8'h44);
        send_frame(16'h0000, 16'd1, 8'h00);

        fill_dbuf(12);
        dbuf[5] = 8'hA5;
        send_frame(16'h0010, 16'd3, 8'h00);
        send_frame(16'h0010, 16'd3, 8'h01);

        fill_dbuf(8);
        send_frame(16'hC7FF, 16'd2, 8'h00);
        fill_dbuf(4);
        send_frame(16'hC7FF, 16'd1, 8'h00);
        dbuf.delete();
        send_frame(16'h0005, 16'd0, 8'h00);

        // Reset lands during the second word's write strobe
        fill_dbuf(12);
        exp_wr.push_back({16'h0020, dbuf[3], dbuf[2], dbuf[1], dbuf[0]});
        send_byte(8'hA5, w);
        send_byte(8'h20, w);
        send_byte(8'h00, w);
        send_byte(8'h03, w);
        send_byte(8'h00, w);
        for (int i = 0; i < 8; i++) send_byte(dbuf[i], w);
        chk("pre_rst_write", mem_write, 1'b1);
        chk("pre_rst_addr", mem_address, 16'h0021);
        reset = 1'b1;
        #1;
        chk("midrst_write", mem_write, 1'b0);
        chk("midrst_cs", mem_chipselect, 1'b0);
        chk("midrst_cpu_rst", cpu_reset_req, 1'b0);
        chk("midrst_ready", in_ready, 1'b0);
        chk("midrst_q", exp_wr.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postrst_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        fill_dbuf(8);
        send_frame(16'h0030, 16'd2, 8'h00);

        repeat (3) @(posedge clk);
        chk("final_wr_q", exp_wr.size(), 0);
        chk("final_res_q", exp_res.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
